// File: rtl/cpu_bus_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_bus_responder_if : 6502 core <-> cpu_bus_responder bus bundle.  Rev 1.0
// ----------------------------------------------------------------------------
interface cpu_bus_responder_if;
  logic [15:0] addr;
  logic [7:0]  d_out;
  logic        write;
  logic [7:0]  d_in;
  logic        ready;

  modport master (output addr, output d_out, output write, input d_in, input ready);
  modport slave  (input addr, input d_out, input write, output d_in, output ready);
endinterface
`default_nettype wire

// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_bus_responder : CPU address decode, work RAM and OAM DMA engine.  Rev 1.0
// Optional open-bus latch enabled by defining OPEN_BUS_EN.
// ----------------------------------------------------------------------------
module cpu_bus_responder #(
  parameter int          RAM_AW   = 11,
  parameter logic [15:0] DMA_PORT = 16'h4014,
  parameter logic [2:0]  OAM_REG  = 3'd4
) (
  input  logic                clk,
  input  logic                reset,
  cpu_bus_responder_if.slave  bus,
  output logic                dma_active,
  output logic                ppu_cs,
  output logic                ppu_we,
  output logic [2:0]          ppu_reg,
  output logic [7:0]          ppu_wdata,
  input  logic [7:0]          ppu_rdata,
  output logic                prg_cs,
  output logic [14:0]         prg_addr,
  input  logic [7:0]          prg_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic [7:0]  r_data;
  logic [7:0]  r_ram [0:(1<<RAM_AW)-1];

  logic [15:0] w_eff_addr;
  logic        w_ram_hit;
  logic        w_ppu_hit;
  logic        w_prg_hit;
  logic        w_start;
  logic        w_cpu_wr;
  logic [7:0]  w_rd_data;
  logic [7:0]  w_open;

  assign dma_active = (r_state != S_IDLE);
  assign bus.ready  = (r_state == S_IDLE);

  // CPU address/write inputs are ignored entirely while DMA owns the bus
  assign w_eff_addr = dma_active ? {r_page, r_index} : bus.addr;
  assign w_ram_hit  = (w_eff_addr[15:13] == 3'b000);
  assign w_ppu_hit  = (w_eff_addr[15:13] == 3'b001);
  assign w_prg_hit  = (w_eff_addr >= 16'h4020);
  assign w_cpu_wr   = bus.write && !dma_active;
  assign w_start    = w_cpu_wr && (bus.addr == DMA_PORT);

  always_comb begin
    w_rd_data = w_open;
    if (w_ram_hit) begin
      w_rd_data = r_ram[w_eff_addr[RAM_AW-1:0]];
    end else if (w_ppu_hit) begin
      w_rd_data = ppu_rdata;
    end else if (w_prg_hit) begin
      w_rd_data = prg_rdata;
    end
  end

  assign bus.d_in = w_rd_data;

`ifdef OPEN_BUS_EN
  logic [7:0] r_open;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_open <= 8'h00;
    end else if (r_state == S_IDLE) begin
      r_open <= bus.write ? bus.d_out : w_rd_data;
    end else if (r_state == S_RD) begin
      r_open <= w_rd_data;
    end
  end

  assign w_open = r_open;
`else
  assign w_open = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (w_cpu_wr && w_ram_hit) begin
      r_ram[bus.addr[RAM_AW-1:0]] <= bus.d_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_index  <= 8'h00;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_next;
      r_parity <= ~r_parity;
      if (r_state == S_IDLE && w_start) begin
        r_page  <= bus.d_out;
        r_index <= 8'h00;
      end
      if (r_state == S_RD) begin
        r_data <= w_rd_data;
      end
      // Index wraps to zero on the final write, leaving it ready for the next run
      if (r_state == S_WR) begin
        r_index <= r_index + 8'd1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    ppu_cs    = 1'b0;
    ppu_we    = 1'b0;
    ppu_reg   = w_eff_addr[2:0];
    ppu_wdata = bus.d_out;
    prg_cs    = 1'b0;
    prg_addr  = w_eff_addr[14:0];
    case (r_state)
      S_IDLE: begin
        ppu_cs = w_ppu_hit;
        ppu_we = w_ppu_hit && bus.write;
        prg_cs = w_prg_hit;
        if (w_start) begin
          w_next = S_HALT;
        end
      end
      // Reads must land on even cycles, so an even HALT needs one extra pad cycle
      S_HALT: begin
        w_next = r_parity ? S_RD : S_ALIGN;
      end
      S_ALIGN: begin
        w_next = S_RD;
      end
      S_RD: begin
        ppu_cs = w_ppu_hit;
        prg_cs = w_prg_hit;
        w_next = S_WR;
      end
      S_WR: begin
        ppu_cs    = 1'b1;
        ppu_we    = 1'b1;
        ppu_reg   = OAM_REG;
        ppu_wdata = r_data;
        w_next    = (r_index == 8'hFF) ? S_IDLE : S_RD;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpu_bus_responder : randomized self-checking bench for cpu_bus_responder.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dma_active;
  logic        ppu_cs;
  logic        ppu_we;
  logic [2:0]  ppu_reg;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata = 8'h00;
  logic        prg_cs;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata = 8'h00;

  cpu_bus_responder_if bus ();

  cpu_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dma_active (dma_active),
    .ppu_cs     (ppu_cs),
    .ppu_we     (ppu_we),
    .ppu_reg    (ppu_reg),
    .ppu_wdata  (ppu_wdata),
    .ppu_rdata  (ppu_rdata),
    .prg_cs     (prg_cs),
    .prg_addr   (prg_addr),
    .prg_rdata  (prg_rdata)
  );

  always #5 clk = ~clk;

  // Reference state: RAM image, which bytes are known, open-bus value, cycle count
  logic [7:0] ram_m   [0:2047];
  logic       ram_ok  [0:2047];
  logic [7:0] ob_m = 8'h00;
  int         cyc;
  int         n_cmp = 0;
  int         n_err = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] unmapped_val();
`ifdef OPEN_BUS_EN
    return ob_m;
`else
    return 8'h00;
`endif
  endfunction

  // One CPU bus cycle with DMA idle; all outputs checked against the address map
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
    logic [7:0] exp_rd;
    logic       is_ram, is_ppu, is_prg, rd_known;
    @(negedge clk);
    bus.addr  = a;
    bus.d_out = d;
    bus.write = w;
    ppu_rdata = 8'($urandom);
    prg_rdata = 8'($urandom);
    #4;
    is_ram   = (a < 16'h2000);
    is_ppu   = (a >= 16'h2000) && (a < 16'h4000);
    is_prg   = (a >= 16'h4020);
    rd_known = 1'b1;
    if (is_ram) begin
      exp_rd   = ram_m[a[10:0]];
      rd_known = ram_ok[a[10:0]];
    end else if (is_ppu) begin
      exp_rd = ppu_rdata;
    end else if (is_prg) begin
      exp_rd = prg_rdata;
    end else begin
      exp_rd = unmapped_val();
    end
    check("ready", bus.ready, 1);
    check("dma_active", dma_active, 0);
    if (rd_known) check("d_in", bus.d_in, exp_rd);
    check("ppu_cs", ppu_cs, is_ppu);
    if (is_ppu) begin
      check("ppu_we", ppu_we, w);
      check("ppu_reg", ppu_reg, a % 8);
      if (w) check("ppu_wdata", ppu_wdata, d);
    end
    check("prg_cs", prg_cs, is_prg);
    if (is_prg) check("prg_addr", prg_addr, a % 32768);
    if (is_ram && w) begin
      ram_m[a[10:0]]  = d;
      ram_ok[a[10:0]] = 1'b1;
    end
    ob_m = w ? d : exp_rd;
  endtask

  // Start OAM DMA from a RAM page on a chosen cycle parity; optionally abort by reset
  task automatic run_dma(input logic [7:0] page, input int start_par, input int abort_at);
    int  low, pulses, exp_low;
    bit  done;
    while (((cyc + 1) % 2) != start_par) cpu_cycle(16'h0000, 8'h00, 1'b0);
    cpu_cycle(16'h4014, page, 1'b1);
    exp_low = (start_par == 0) ? 513 : 514;
    low = 0; pulses = 0; done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (low + 1 <= exp_low) begin
        bus.addr  = 16'($urandom);
        bus.d_out = 8'($urandom);
        bus.write = 1'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          bus.addr  = 16'h4014;
          bus.write = 1'b1;
        end
      end else begin
        bus.addr  = 16'h0000;
        bus.write = 1'b0;
      end
      ppu_rdata = 8'($urandom);
      prg_rdata = 8'($urandom);
      #4;
      if (bus.ready) begin
        done = 1'b1;
      end else begin
        low++;
        if (low == 1) check("dma_active_on", dma_active, 1);
        if (ppu_we) begin
          check("dma_reg", ppu_reg, 4);
          check("dma_data", ppu_wdata, ram_m[{page[2:0], pulses[7:0]}]);
          if (pulses == 0) check("dma_first_wr_odd", cyc % 2, 1);
          pulses++;
          if (abort_at != 0 && pulses == abort_at) begin
            @(negedge clk);
            bus.addr  = 16'h0000;
            bus.write = 1'b0;
            #2 reset = 1'b0;
            #1;
            check("abort_ready", bus.ready, 1);
            check("abort_dma_active", dma_active, 0);
            ob_m = 8'h00;
            @(negedge clk);
            reset = 1'b1;
            return;
          end
        end
      end
    end
    check("dma_finished", done, 1);
    check("dma_low_cycles", low, exp_low);
    check("dma_pulses", pulses, 256);
    check("dma_active_after", dma_active, 0);
    ob_m = ram_m[{page[2:0], 8'hFF}];
  endtask

  initial begin
    logic [15:0] a;
    logic        w;
    for (int i = 0; i < 2048; i++) begin
      ram_m[i]  = 8'h00;
      ram_ok[i] = 1'b0;
    end
    bus.addr  = 16'h0000;
    bus.d_out = 8'h00;
    bus.write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", bus.ready, 1);
    check("reset_dma_active", dma_active, 0);
    @(negedge clk);
    reset = 1'b1;

    // Mirrored RAM, PPU window, unmapped read after a RAM write
    cpu_cycle(16'h0001, 8'hA5, 1'b1);
    cpu_cycle(16'h0801, 8'h00, 1'b0);
    check("mirror_0801", bus.d_in, 8'hA5);
    cpu_cycle(16'h1001, 8'h00, 1'b0);
    cpu_cycle(16'h1801, 8'h00, 1'b0);
    check("mirror_1801", bus.d_in, 8'hA5);
    cpu_cycle(16'h2009, 8'h3C, 1'b1);
    cpu_cycle(16'h3FFA, 8'h00, 1'b0);
    cpu_cycle(16'h0000, 8'h77, 1'b1);
    cpu_cycle(16'h4015, 8'h00, 1'b0);
`ifdef OPEN_BUS_EN
    check("open_bus_4015", bus.d_in, 8'h77);
`else
    check("open_bus_4015", bus.d_in, 8'h00);
`endif

    // Make the whole RAM image known, then random traffic across the map
    for (int i = 0; i < 2048; i++) cpu_cycle(16'(i), 8'($urandom), 1'b1);
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 16'h1FFF));
        1: a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2: a = 16'($urandom_range(16'h4020, 16'hFFFF));
        default: begin
          a = 16'($urandom_range(16'h4000, 16'h401F));
          if (a == 16'h4014) w = 1'b0;
        end
      endcase
      cpu_cycle(a, 8'($urandom), w);
    end

    // OAM DMA from $0200 on even and odd starts, a mirrored page, then an aborted run
    for (int i = 0; i < 256; i++) cpu_cycle(16'h0200 + 16'(i), 8'(i) ^ 8'h5A, 1'b1);
    run_dma(8'h02, 0, 0);
    cpu_cycle(16'h0200, 8'h00, 1'b0);
    run_dma(8'h02, 1, 0);
    run_dma(8'h1F, int'($urandom_range(0, 1)), 0);
    run_dma(8'h02, 0, 100);
    cpu_cycle(16'h0200, 8'h00, 1'b0);
    check("post_abort_ram", bus.d_in, 8'h5A);
    cpu_cycle(16'h4015, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
